// File: rtl/md5_sched_if.sv
// Link between md5_sched and its md5core: candidate blocks go out, digests and
// the block that produced them come back.
interface md5_sched_if;
    logic         core_en;
    logic [511:0] core_m;
    logic         core_valid;
    logic [31:0]  core_a;
    logic [31:0]  core_b;
    logic [31:0]  core_c;
    logic [31:0]  core_d;
    logic [511:0] core_m_ret;
    logic         core_valid_in;

    modport master (
        output core_en, core_m, core_valid,
        input  core_a, core_b, core_c, core_d, core_m_ret, core_valid_in
    );

    modport slave (
        input  core_en, core_m, core_valid,
        output core_a, core_b, core_c, core_d, core_m_ret, core_valid_in
    );
endinterface

// File: rtl/md5_sched.sv
// Issue controller for a pipelined md5core: streams counter-stamped candidate
// blocks, compares returning digests against a target and captures the first hit.
module md5_sched #(
    parameter int PIPE_LATENCY  = 64,
    parameter int CNT_LSB       = 448,
    parameter int STOP_ON_MATCH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [511:0] base_mesg,
    input  logic [31:0]  ctr_start,
    input  logic [31:0]  count,
    input  logic [31:0]  target_a,
    input  logic [31:0]  target_b,
    input  logic [31:0]  target_c,
    input  logic [31:0]  target_d,
    md5_sched_if.master  core,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic [511:0] match_mesg,
    output logic [31:0]  match_ctr,
    output logic [31:0]  issued,
    output logic         timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    localparam logic [511:0] FIELD_MASK = {480'b0, 32'hFFFF_FFFF} << CNT_LSB;
    localparam logic [31:0]  WD_LIMIT   = 32'(PIPE_LATENCY + 8);

    state_t       state_reg;
    logic [511:0] base_reg;
    logic [31:0]  ctr_reg;
    logic [31:0]  count_reg;
    logic [31:0]  ret_reg;
    logic [31:0]  wd_reg;

    logic [511:0] tmpl_src;
    logic [31:0]  ctr_src;
    logic [511:0] cand_mesg;
    logic [127:0] digest;
    logic [127:0] target;
    logic [3:0]   word_eq;
    logic         hit;

    // In IDLE the first candidate is built straight from the inputs so it can
    // be issued on the cycle right after start.
    assign tmpl_src  = (state_reg == ST_IDLE) ? base_mesg : base_reg;
    assign ctr_src   = (state_reg == ST_IDLE) ? ctr_start : ctr_reg;
    assign cand_mesg = (tmpl_src & ~FIELD_MASK) | (512'(ctr_src) << CNT_LSB);

    assign digest = {core.core_a, core.core_b, core.core_c, core.core_d};
    assign target = {target_a, target_b, target_c, target_d};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word_cmp
            assign word_eq[gi] = (digest[gi*32 +: 32] == target[gi*32 +: 32]);
        end
    endgenerate

    assign hit = core.core_valid_in && (&word_eq);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            base_reg        <= '0;
            ctr_reg         <= '0;
            count_reg       <= '0;
            ret_reg         <= '0;
            wd_reg          <= '0;
            core.core_en    <= 1'b0;
            core.core_m     <= '0;
            core.core_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            match           <= 1'b0;
            match_mesg      <= '0;
            match_ctr       <= '0;
            issued          <= '0;
            timeout         <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state_reg != ST_IDLE) begin
                if (core.core_valid_in) begin
                    ret_reg <= ret_reg + 32'd1;
                end
                if (hit && !match) begin
                    match      <= 1'b1;
                    match_mesg <= core.core_m_ret;
                    match_ctr  <= core.core_m_ret[CNT_LSB +: 32];
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        base_reg  <= base_mesg;
                        ctr_reg   <= ctr_start + 32'd1;
                        count_reg <= count;
                        ret_reg   <= '0;
                        wd_reg    <= '0;
                        match     <= 1'b0;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                        if (count != 32'd0) begin
                            state_reg       <= ST_ISSUE;
                            core.core_en    <= 1'b1;
                            core.core_valid <= 1'b1;
                            core.core_m     <= cand_mesg;
                            issued          <= 32'd1;
                        end else begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            issued    <= '0;
                        end
                    end
                end

                ST_ISSUE: begin
                    // issued already counts the candidate on the bus this cycle
                    if (stop || ((STOP_ON_MATCH != 0) && hit) || (issued == count_reg)) begin
                        state_reg       <= ST_DRAIN;
                        core.core_valid <= 1'b0;
                        core.core_m     <= '0;
                        wd_reg          <= '0;
                    end else begin
                        core.core_valid <= 1'b1;
                        core.core_m     <= cand_mesg;
                        ctr_reg         <= ctr_reg + 32'd1;
                        issued          <= issued + 32'd1;
                    end
                end

                ST_DRAIN: begin
                    wd_reg <= wd_reg + 32'd1;
                    if (ret_reg == issued) begin
                        state_reg    <= ST_DONE;
                        done         <= 1'b1;
                        core.core_en <= 1'b0;
                    end else if (wd_reg == WD_LIMIT) begin
                        state_reg    <= ST_DONE;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        core.core_en <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_sched.sv
// Bench for md5_sched: a fixed-latency stand-in core with a simple fold digest,
// a done-driven scoreboard and an issue monitor checking every candidate block.
module tb_md5_sched;

    localparam int PL = 64;
    localparam int CL = 448;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [511:0] base_mesg;
    logic [31:0]  ctr_start;
    logic [31:0]  count;
    logic [31:0]  target_a;
    logic [31:0]  target_b;
    logic [31:0]  target_c;
    logic [31:0]  target_d;
    logic         busy;
    logic         done;
    logic         match;
    logic [511:0] match_mesg;
    logic [31:0]  match_ctr;
    logic [31:0]  issued;
    logic         timeout;

    md5_sched_if core_bus ();

    md5_sched #(.PIPE_LATENCY(PL), .CNT_LSB(CL), .STOP_ON_MATCH(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .base_mesg  (base_mesg),
        .ctr_start  (ctr_start),
        .count      (count),
        .target_a   (target_a),
        .target_b   (target_b),
        .target_c   (target_c),
        .target_d   (target_d),
        .core       (core_bus),
        .busy       (busy),
        .done       (done),
        .match      (match),
        .match_mesg (match_mesg),
        .match_ctr  (match_ctr),
        .issued     (issued),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in digest: unique per counter value within a template.
    function automatic logic [127:0] toy(input logic [511:0] m);
        logic [31:0] x;
        logic [31:0] s;
        x = '0;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            x = x ^ m[i*32 +: 32];
            s = s + m[i*32 +: 32];
        end
        return {x, s, x ^ 32'h5a5a_5a5a, s + {x[15:0], x[31:16]}};
    endfunction

    logic         stall = 1'b0;
    logic         pv [PL];
    logic [511:0] pm [PL];
    logic [127:0] dig;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PL; i++) pv[i] <= 1'b0;
        end else if (core_bus.core_en) begin
            pv[0] <= core_bus.core_valid;
            pm[0] <= core_bus.core_m;
            for (int i = 1; i < PL; i++) begin
                pv[i] <= pv[i-1];
                pm[i] <= pm[i-1];
            end
        end
    end

    assign dig                    = toy(pm[PL-1]);
    assign core_bus.core_a        = dig[127:96];
    assign core_bus.core_b        = dig[95:64];
    assign core_bus.core_c        = dig[63:32];
    assign core_bus.core_d        = dig[31:0];
    assign core_bus.core_m_ret    = pm[PL-1];
    assign core_bus.core_valid_in = pv[PL-1] & ~stall;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         exp_match;
        logic [31:0]  exp_ctr;
        logic [511:0] exp_mesg;
        int           exp_issued;   // -1: only bounded by count
        logic         exp_timeout;
        int           exp_offset;   // done cycle minus first cycle after start; -1: skip
        int           start_cyc;
    } exp_t;

    exp_t        q[$];
    string       q_name[$];
    logic [31:0] run_base;
    logic [511:0] run_tmpl;
    int          issue_k;
    int          vcount;
    int          hit_cyc;
    bit          done_seen;
    logic [31:0] seen_fields[$];

    logic [511:0] fmask;
    assign fmask = {480'b0, 32'hFFFF_FFFF} << CL;

    // Issue monitor: every candidate must be the template stamped with base+k.
    always @(negedge clk) begin
        if (!reset && core_bus.core_valid) begin
            chk("issue_field", core_bus.core_m[CL +: 32], 32'(run_base + 32'(issue_k)));
            chk("issue_tmpl", 64'(((core_bus.core_m ^ run_tmpl) & ~fmask) == '0), 64'd1);
            seen_fields.push_back(core_bus.core_m[CL +: 32]);
            issue_k++;
            vcount++;
        end
        if (!reset && core_bus.core_valid_in && hit_cyc < 0 &&
            dig == {target_a, target_b, target_c, target_d})
            hit_cyc = cyc;
    end

    // Scoreboard monitor: pops one expected record per done pulse.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                exp_t  e;
                string nm;
                e  = q.pop_front();
                nm = q_name.pop_front();
                $display("run %s: issued=%0d valid_cycles=%0d match=%0b match_ctr=%08h timeout=%0b cycles=%0d",
                         nm, issued, vcount, match, match_ctr, timeout, cyc - e.start_cyc);
                chk({nm, ".match"}, 64'(match), 64'(e.exp_match));
                chk({nm, ".timeout"}, 64'(timeout), 64'(e.exp_timeout));
                chk({nm, ".busy"}, 64'(busy), 64'd1);
                if (e.exp_match) begin
                    chk({nm, ".match_ctr"}, 64'(match_ctr), 64'(e.exp_ctr));
                    chk({nm, ".match_mesg"}, 64'(match_mesg == e.exp_mesg), 64'd1);
                end
                if (e.exp_issued >= 0) begin
                    chk({nm, ".issued"}, 64'(issued), 64'(e.exp_issued));
                    chk({nm, ".valid_cycles"}, 64'(vcount), 64'(e.exp_issued));
                end else begin
                    chk({nm, ".issued_lt_count"}, 64'(issued < 32'd1000 && issued >= 32'd4), 64'd1);
                    chk({nm, ".valid_cycles"}, 64'(vcount), 64'(issued));
                    chk({nm, ".done_after_hit"}, 64'(hit_cyc >= 0 && (cyc - hit_cyc) <= PL + 3), 64'd1);
                end
                if (e.exp_offset >= 0)
                    chk({nm, ".done_cycle"}, 64'(cyc - e.start_cyc), 64'(e.exp_offset));
            end
            done_seen = 1'b1;
        end
    end

    task automatic run(input string nm, input logic [511:0] tm, input logic [31:0] c0,
                       input logic [31:0] cnt, input logic [127:0] tgt, input int stop_after,
                       input logic em, input logic [31:0] ectr, input int eiss,
                       input logic eto, input int eoff);
        exp_t e;
        {target_a, target_b, target_c, target_d} = tgt;
        base_mesg = tm;
        ctr_start = c0;
        count     = cnt;
        run_base  = c0;
        run_tmpl  = tm;
        issue_k   = 0;
        vcount    = 0;
        hit_cyc   = -1;
        done_seen = 1'b0;
        seen_fields.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.exp_match   = em;
        e.exp_ctr     = ectr;
        e.exp_mesg    = (tm & ~fmask) | (512'(ectr) << CL);
        e.exp_issued  = eiss;
        e.exp_timeout = eto;
        e.exp_offset  = eoff;
        e.start_cyc   = cyc;
        q.push_back(e);
        q_name.push_back(nm);
        if (stop_after > 0) begin
            repeat (stop_after - 1) @(posedge clk);
            #1;
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
        end
        for (int i = 0; i < 4000 && !done_seen; i++) @(posedge clk);
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.done_wait: got no done within 4000 cycles, required a done pulse", nm);
            q.delete();
            q_name.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [511:0] fox;
    logic [511:0] hello;
    logic [127:0] fox_t;
    logic [31:0]  wrap_exp [4];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        base_mesg = '0;
        ctr_start = '0;
        count     = '0;
        {target_a, target_b, target_c, target_d} = '0;

        fox = '0;
        fox[511 -: 344] = "The quick brown fox jumps over the lazy dog";
        fox[167 -: 8]   = 8'h80;
        fox[63:0]       = 64'h5801_0000_0000_0000;
        hello = '0;
        hello[511 -: 88] = "Hello World";
        hello[423 -: 8]  = 8'h80;
        hello[63:0]      = 64'h5800_0000_0000_0000;
        fox_t = toy(fox);
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.match", 64'(match), 64'd0);
        chk("rst.core_en", 64'(core_bus.core_en), 64'd0);
        chk("rst.core_valid", 64'(core_bus.core_valid), 64'd0);
        chk("rst.issued", 64'(issued), 64'd0);
        chk("rst.timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run("fox",   fox,   32'h7175_6960, 32'd8,    fox_t,  0, 1'b1, 32'h7175_6963, 8,  1'b0, 8 + PL + 1);
        run("early", fox,   32'h7175_6960, 32'd1000, fox_t,  0, 1'b1, 32'h7175_6963, -1, 1'b0, -1);
        run("hello", hello, 32'h0000_0000, 32'd16,   128'h0, 0, 1'b0, 32'h0,         16, 1'b0, 16 + PL + 1);
        run("stop",  hello, 32'h0000_0100, 32'd100,  128'h0, 5, 1'b0, 32'h0,         5,  1'b0, 5 + PL + 1);
        run("zero",  hello, 32'h0000_0000, 32'd0,    128'h0, 0, 1'b0, 32'h0,         0,  1'b0, 0);
        run("wrap",  hello, 32'hFFFF_FFFE, 32'd4,    128'h0, 0, 1'b0, 32'h0,         4,  1'b0, 4 + PL + 1);
        chk("wrap.n_fields", 64'(seen_fields.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen_fields.size(); i++)
            chk($sformatf("wrap.field%0d", i), 64'(seen_fields[i]), 64'(wrap_exp[i]));

        stall = 1'b1;
        run("stall", hello, 32'h0000_0000, 32'd4, 128'h0, 0, 1'b0, 32'h0, 4, 1'b1, PL + 13);
        stall = 1'b0;

        // Reset while candidates are still being issued.
        base_mesg = hello;
        ctr_start = 32'h0000_0200;
        count     = 32'd100;
        run_base  = 32'h0000_0200;
        run_tmpl  = hello;
        issue_k   = 0;
        vcount    = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.busy", 64'(busy), 64'd0);
        chk("mid.core_valid", 64'(core_bus.core_valid), 64'd0);
        chk("mid.core_en", 64'(core_bus.core_en), 64'd0);
        chk("mid.match", 64'(match), 64'd0);
        chk("mid.issued", 64'(issued), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run("after_rst", fox, 32'h7175_6962, 32'd3, fox_t, 0, 1'b1, 32'h7175_6963, 3, 1'b0, 3 + PL + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md5_sched.md
# md5_sched

Issue controller for the pipelined `md5core`. On `start` it streams `count` candidate 512-bit blocks into the core, one per clock. Each block is a padded template with a 32-bit counter field overwritten by successive values. The block compares every digest leaving the pipeline against a target, captures the first matching block, and reports completion. It sits between the host/command logic and one `md5core` instance, and owns that core's `en`, `m_in` and `valid_in`.

## Interface
Parameters:
- `PIPE_LATENCY`, 64: cycles from `core_valid` high to the matching `core_valid_in` high.
- `CNT_LSB`, 448: LSB of the counter field inside the block (field is bits [CNT_LSB+31:CNT_LSB]).
- `STOP_ON_MATCH`, 1: 1 = stop issuing on the first match.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; ignored unless IDLE
- `stop`  in  1  one-cycle abort pulse
- `base_mesg`  in  512  padded block template, captured on start
- `ctr_start`  in  32  first counter value, captured on start
- `count`  in  32  number of candidates, captured on start
- `target_a`/`target_b`/`target_c`/`target_d`  in  32 each  expected digest words
- `core_en`  out  1  to md5core `en`
- `core_m`  out  512  to md5core `m_in`
- `core_valid`  out  1  to md5core `valid_in`
- `core_a`/`core_b`/`core_c`/`core_d`  in  32 each  from md5core `a_out`..`d_out`
- `core_m_ret`  in  512  from md5core `m_out`
- `core_valid_in`  in  1  from md5core `valid_out`
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `match`  out  1  a match was found in this run (sticky until next start)
- `match_mesg`  out  512  block that matched
- `match_ctr`  out  32  counter field of `match_mesg`
- `issued`  out  32  candidates issued this run
- `timeout`  out  1  drain watchdog fired (sticky until next start)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `start`: latch `base_mesg`, `ctr_start` and `count`; clear `issued`, returned count, `match` and `timeout`.
  - Go to ISSUE if `count` is not 0, otherwise go to DONE.
- **ISSUE**
  - Each cycle: drive `core_valid`=1 and `core_m` = template with field set to `ctr`; then `ctr`+1 and `issued`+1.
  - After issuing the `count`-th candidate, go to DRAIN.
  - `stop`, or a match with `STOP_ON_MATCH`=1, also goes to DRAIN; nothing is issued that cycle or after.
- **DRAIN**
  - `core_valid`=0 and `core_m`=0.
  - Wait until returned count equals `issued`, then go to DONE.
  - Watchdog: if this takes more than `PIPE_LATENCY`+8 cycles after entering DRAIN, set `timeout` and go to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `core_en`=1 in ISSUE and DRAIN, 0 in IDLE and DONE. The pipeline is frozen only when it is empty.
- Returns are counted in every non-IDLE state whenever `core_valid_in`=1.
- **Compare:** when `core_valid_in` and {`core_a`,`core_b`,`core_c`,`core_d`} equals {`target_a`,`target_b`,`target_c`,`target_d`}:
  - If `match`=0: set `match`, capture `core_m_ret` into `match_mesg` and its bits [CNT_LSB+31:CNT_LSB] into `match_ctr`.
  - Later matches are ignored.
- **Counter width:** the counter is 32-bit and wraps 0xFFFFFFFF→0 with no flag. `issued` cannot wrap because it is bounded by `count`.
- **`stop` outside ISSUE:** ignored. `start` outside IDLE: ignored.
- **Same-cycle events:** a match and the last issue in the same cycle still go to DRAIN. `stop` and `start` together in IDLE: `start` wins.
- **Reset** (any state, including mid-run): go to IDLE. All outputs 0, including `core_en`. `match_mesg`, `match_ctr` and `issued` are cleared to 0.

## Timing
- All outputs are registered.
- `start` at edge N: first `core_valid` is high in cycle N+1. `count` candidates occupy cycles N+1..N+count.
- Last result returns `PIPE_LATENCY` cycles after the last issue.
- `done` is high in cycle N+count+`PIPE_LATENCY`+2.
- `count`=0: `done` is high in cycle N+1.
- `match` and `match_mesg` update in the cycle after the matching `core_valid_in`. They are valid no later than `done`.
- `busy` is high from the cycle after `start` through the `done` cycle.

## Test plan
- **Quick-brown-fox match:**
  - Stimulus: template = padded "The quick brown fox jumps over the lazy dog", `CNT_LSB`=448, `ctr_start`=0x71756960, `count`=8, target = md5core digest of that message (MD5 9e107d9d372bb6826bd81d3542a419d6), `STOP_ON_MATCH`=0.
  - Required: `match`=1, `match_ctr`=0x71756963, `issued`=8, `done` at N+8+`PIPE_LATENCY`+2.
- **Early stop:**
  - Stimulus: same run with `STOP_ON_MATCH`=1, `count`=1000.
  - Required: `match`=1 and `issued` < 1000. `done` arrives within `PIPE_LATENCY`+3 cycles of the match return.
- **No match ("Hello World" template):**
  - Stimulus: `count`=16, target all zeros.
  - Required: `match`=0, `timeout`=0, `issued`=16, exactly 16 `core_valid` cycles, consecutive `core_m` counter fields increment by 1.
- **Abort and zero count:**
  - `stop` 5 cycles after `start` with `count`=100 → `issued`=5, `done` after the drain.
  - `count`=0 → `done` at N+1, no `core_valid`.
- **Wrap and stalled core:**
  - `ctr_start`=0xFFFFFFFE, `count`=4 → fields issued are FFFFFFFE, FFFFFFFF, 0, 1.
  - Core model holding `core_valid_in` low → `timeout`=1, `done` at `PIPE_LATENCY`+9 cycles after DRAIN entry.
- **Reset mid-ISSUE:**
  - Required: next cycle `busy`, `core_valid`, `core_en` and `match` are all 0.
  - A new `start` then runs normally.
